// File: rtl/io_seq_monitor_pkg.sv
// io_seq_monitor_pkg: FSM encoding and mode constants shared by
// the io_seq_monitor result-sequence checker and its timer.
package io_seq_monitor_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RDY,
    RUN,
    PASS,
    FAIL,
    TIMEOUT
  } state_t;

  localparam logic MODE_EVENTUAL = 1'b0;
  localparam logic MODE_STRICT   = 1'b1;

  // start is honoured only outside an active sequence
  function automatic logic can_arm(input state_t s);
    return (s == IDLE) || (s == PASS) ||
           (s == FAIL) || (s == TIMEOUT);
  endfunction

endpackage

// File: rtl/io_seq_timer.sv
// io_seq_timer: per-step cycle counter with clear/enable and a
// programmable limit; a zero limit never expires.
module io_seq_timer
  import io_seq_monitor_pkg::*;
#(
  parameter int TO_W = 24
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_clr,
  input  logic            i_en,
  input  logic [TO_W-1:0] i_limit,
  output logic            o_expired
);

  typedef logic [TO_W-1:0] cnt_t;
  localparam cnt_t LP_ONE = cnt_t'(1);

  cnt_t r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + LP_ONE;
    end
  end

  assign o_expired = (i_limit != '0) &&
                     (r_count == i_limit);

endmodule

// File: rtl/io_seq_monitor.sv
// io_seq_monitor: steps through a programmed list of expected bus
// values with per-step timeout. Strict mode: IO_SEQ_MONITOR_STRICT_EN.
module io_seq_monitor
  import io_seq_monitor_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 16,
  parameter  int TO_W  = 24,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [WIDTH-1:0] cfg_data,
  input  logic [AW:0]      cfg_len,
  input  logic [TO_W-1:0]  cfg_timeout,
  input  logic             cfg_strict,
  input  logic             start,
  input  logic             abort,
  input  logic             obs_ready,
  input  logic [WIDTH-1:0] obs_data,
  output logic             busy,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [AW:0]      step_idx,
  output logic [WIDTH-1:0] last_obs
);

  typedef logic [AW:0]   idx_t;
  typedef logic [AW-1:0] rd_t;

  localparam idx_t LP_DEPTH = idx_t'(DEPTH);
  localparam idx_t LP_ONE   = idx_t'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_exp [DEPTH];
  logic [WIDTH-1:0] r_obs_q;
  idx_t             r_step_idx;
  idx_t             r_len;
  logic [TO_W-1:0]  r_to;

  idx_t             w_len_clamp;
  idx_t             w_idx_inc;
  rd_t              w_rd;
  logic [WIDTH-1:0] w_exp_cur;
  logic             w_busy;
  logic             w_arm;
  logic             w_match;
  logic             w_adv;
  logic             w_fail;
  logic             w_mode;
  logic             w_strict;
  logic             w_chg;
  logic             w_dup;
  logic             w_expired;
  logic             w_tmr_clr;
  logic             w_tmr_en;

  assign w_busy = (r_state == WAIT_RDY) ||
                  (r_state == RUN);
  assign w_arm  = start && !abort &&
                  can_arm(r_state);

  assign w_len_clamp = (cfg_len > LP_DEPTH) ?
                       LP_DEPTH : cfg_len;
  assign w_idx_inc   = r_step_idx + LP_ONE;
  assign w_rd        = r_step_idx[AW-1:0];
  assign w_exp_cur   = r_exp[w_rd];
  assign w_match     = (r_obs_q == w_exp_cur);
  assign w_strict    = (w_mode == MODE_STRICT);

`ifdef IO_SEQ_MONITOR_STRICT_EN
  localparam rd_t LP_RD_ONE = rd_t'(1);

  logic             r_mode;
  logic             r_first;
  logic             r_adv_q;
  logic [WIDTH-1:0] r_obs_prev;
  rd_t              w_rd_prev;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_mode     <= MODE_EVENTUAL;
      r_first    <= 1'b0;
      r_adv_q    <= 1'b0;
      r_obs_prev <= '0;
    end else begin
      r_obs_prev <= r_obs_q;
      r_adv_q    <= w_adv;
      r_first    <= (r_state == WAIT_RDY) &&
                    (w_state_nxt == RUN);
      if (w_arm) begin
        r_mode <= cfg_strict ? MODE_STRICT
                             : MODE_EVENTUAL;
      end
    end
  end

  // a repeated entry is owed to the match just made, not to a new edge
  assign w_rd_prev = w_rd - LP_RD_ONE;
  assign w_mode    = r_mode;
  assign w_chg     = r_first ||
                     (r_obs_q != r_obs_prev);
  assign w_dup     = w_strict && r_adv_q &&
                     (r_step_idx != '0) &&
                     (w_exp_cur == r_exp[w_rd_prev]);
`else
  logic w_unused;

  assign w_mode   = MODE_EVENTUAL;
  assign w_chg    = 1'b1;
  assign w_dup    = 1'b0;
  assign w_unused = cfg_strict;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_adv       = 1'b0;
    w_fail      = 1'b0;
    if (abort) begin
      w_state_nxt = IDLE;
    end else if (w_arm) begin
      w_state_nxt = WAIT_RDY;
    end else begin
      unique case (r_state)
        WAIT_RDY: begin
          if (obs_ready) begin
            w_state_nxt = (r_len == '0) ? PASS : RUN;
          end
        end
        RUN: begin
          if (w_dup) begin
            w_adv = 1'b1;
          end else if (!w_strict || w_chg) begin
            w_adv  = w_match;
            w_fail = w_strict && !w_match;
          end
          // an advance beats a timer expiring in the same cycle
          if (w_adv) begin
            w_state_nxt = (w_idx_inc == r_len) ?
                          PASS : RUN;
          end else if (w_fail) begin
            w_state_nxt = FAIL;
          end else if (w_expired) begin
            w_state_nxt = TIMEOUT;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_state    <= IDLE;
      r_obs_q    <= '0;
      r_step_idx <= '0;
      r_len      <= '0;
      r_to       <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_obs_q <= obs_data;
      if (abort || w_arm) begin
        r_step_idx <= '0;
      end else if (w_adv) begin
        r_step_idx <= w_idx_inc;
      end
      if (w_arm) begin
        r_len <= w_len_clamp;
        r_to  <= cfg_timeout;
      end
    end
  end

  // expected list is plain storage, no reset
  always_ff @(posedge clock) begin
    if (cfg_we && !w_busy) begin
      r_exp[cfg_addr] <= cfg_data;
    end
  end

  assign w_tmr_clr = abort || w_arm || w_adv;
  assign w_tmr_en  = (r_state == RUN);

  io_seq_timer #(
    .TO_W (TO_W)
  ) u_timer (
    .i_clk     (clock),
    .i_rst_n   (resetb),
    .i_clr     (w_tmr_clr),
    .i_en      (w_tmr_en),
    .i_limit   (r_to),
    .o_expired (w_expired)
  );

  assign busy     = w_busy;
  assign pass     = (r_state == PASS);
  assign fail     = (r_state == FAIL);
  assign timeout  = (r_state == TIMEOUT);
  assign step_idx = r_step_idx;
  assign last_obs = r_obs_q;

endmodule

// File: tb/tb_io_seq_monitor.sv
// tb_io_seq_monitor: directed stimulus with a queue-based reference
// model compared every cycle, plus hand-computed end-of-test values.
module tb_io_seq_monitor;

`ifdef IO_SEQ_MONITOR_STRICT_EN
  localparam bit STRICT_BUILT = 1'b1;
`else
  localparam bit STRICT_BUILT = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        resetb = 1'b0;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_addr = '0;
  logic [15:0] cfg_data = '0;
  logic [4:0]  cfg_len = '0;
  logic [23:0] cfg_timeout = '0;
  logic        cfg_strict = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        obs_ready = 1'b0;
  logic [15:0] obs_data = '0;
  logic        busy, pass, fail, timeout;
  logic [4:0]  step_idx;
  logic [15:0] last_obs;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  io_seq_monitor #(
    .WIDTH (16),
    .DEPTH (16),
    .TO_W  (24)
  ) dut (
    .clock       (clock),
    .resetb      (resetb),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .cfg_len     (cfg_len),
    .cfg_timeout (cfg_timeout),
    .cfg_strict  (cfg_strict),
    .start       (start),
    .abort       (abort),
    .obs_ready   (obs_ready),
    .obs_data    (obs_data),
    .busy        (busy),
    .pass        (pass),
    .fail        (fail),
    .timeout     (timeout),
    .step_idx    (step_idx),
    .last_obs    (last_obs)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h expected %0h @%0t",
                 nm, act, exp, $time);
    end
  endtask

  // ---- reference model: status 0 idle,1 wait,2 run,3 pass,4 fail,5 tmo
  int          m_st = 0;
  int          m_idx = 0;
  int          m_stall = 0;
  int          m_len = 0;
  logic [23:0] m_to = '0;
  bit          m_strict = 0;
  logic [15:0] m_mem [16];
  logic [15:0] m_rem [$];
  logic [15:0] m_obs = '0;
  logic [15:0] m_prev = '0;
  logic [15:0] m_lastpop = '0;
  bit          m_fresh = 0;
  bit          m_popped = 0;

  always @(posedge clock or negedge resetb) begin
    bit adv, chg, bsy, was_fresh, was_pop;
    if (!resetb) begin
      m_st = 0; m_idx = 0; m_stall = 0;
      m_obs = '0; m_prev = '0;
      m_fresh = 0; m_popped = 0;
      m_rem.delete();
    end else begin
      adv = 0;
      bsy = (m_st == 1) || (m_st == 2);
      was_fresh = m_fresh;
      was_pop = m_popped;
      m_fresh = 0;
      m_popped = 0;
      if (cfg_we && !bsy) m_mem[cfg_addr] = cfg_data;
      if (abort) begin
        m_st = 0; m_idx = 0; m_stall = 0;
      end else if (start && !bsy) begin
        m_len = (cfg_len > 16) ? 16 : int'(cfg_len);
        m_rem.delete();
        for (int i = 0; i < m_len; i++)
          m_rem.push_back(m_mem[i]);
        m_to = cfg_timeout;
        m_strict = cfg_strict && STRICT_BUILT;
        m_idx = 0; m_stall = 0; m_st = 1;
      end else if (m_st == 1) begin
        if (obs_ready) begin
          if (m_rem.size() == 0) m_st = 3;
          else begin m_st = 2; m_fresh = 1; end
        end
      end else if (m_st == 2) begin
        chg = was_fresh || (m_obs != m_prev);
        if (m_strict && was_pop && m_rem[0] == m_lastpop)
          adv = 1;
        else if ((!m_strict || chg) && m_obs == m_rem[0])
          adv = 1;
        else if (m_strict && chg)
          m_st = 4;
        if (adv) begin
          m_lastpop = m_rem.pop_front();
          m_idx++;
          m_stall = 0;
          m_popped = 1;
          if (m_rem.size() == 0) m_st = 3;
        end else if (m_st == 2) begin
          if (m_to != 0 && m_stall == int'(m_to)) m_st = 5;
          m_stall++;
        end
      end
      m_prev = m_obs;
      m_obs = obs_data;
    end
  end

  always @(negedge clock) begin
    if (resetb) begin
      chk("cyc_busy", busy, (m_st == 1 || m_st == 2));
      chk("cyc_pass", pass, (m_st == 3));
      chk("cyc_fail", fail, (m_st == 4));
      chk("cyc_timeout", timeout, (m_st == 5));
      chk("cyc_step_idx", step_idx, m_idx);
      chk("cyc_last_obs", last_obs, m_obs);
    end
  end

  // ---- stimulus helpers (inputs change on negedge)
  task automatic wr(input int a, input logic [15:0] d);
    cfg_we = 1'b1;
    cfg_addr = 4'(a);
    cfg_data = d;
    @(negedge clock);
    cfg_we = 1'b0;
  endtask

  task automatic arm(input int len, input int to,
                     input bit strict);
    cfg_len = 5'(len);
    cfg_timeout = 24'(to);
    cfg_strict = strict;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic drive(input logic [15:0] v, input int n);
    obs_data = v;
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_abort(input bit with_start);
    abort = 1'b1;
    start = with_start;
    @(negedge clock);
    abort = 1'b0;
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int lim);
    int k = 0;
    while (busy && k < lim) begin
      @(negedge clock);
      k++;
    end
    chk(nm, busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_pass", pass, 0);
    chk("rst_fail", fail, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_step_idx", step_idx, 0);
    chk("rst_last_obs", last_obs, 0);
    #2 resetb = 1'b1;
    @(negedge clock);

    // eventual mode with repeated entries
    obs_ready = 1'b1;
    wr(0, 16'h0001); wr(1, 16'h0001); wr(2, 16'h0001);
    wr(3, 16'h0000); wr(4, 16'h0001);
    obs_data = 16'h0001;
    arm(5, 0, 0);
    drive(16'h0001, 3);
    drive(16'h0000, 1);
    drive(16'h0001, 1);
    wait_done("t1_done", 20);
    chk("t1_pass", pass, 1);
    chk("t1_step", step_idx, 5);

    // eventual mode ignores intervening values
    wr(0, 16'h449A); wr(1, 16'h3042); wr(2, 16'h491E);
    obs_data = 16'h0000;
    arm(3, 0, 0);
    drive(16'h449A, 1); drive(16'hFFFF, 1);
    drive(16'h3042, 1); drive(16'h1234, 1);
    drive(16'h491E, 1);
    wait_done("t2_done", 20);
    chk("t2_pass", pass, 1);
    chk("t2_step", step_idx, 3);

    // strict mode: a wrong new value fails
    obs_data = 16'h0000;
    arm(3, 0, 1);
    drive(16'h449A, 1);
    drive(16'hFFFF, 3);
`ifdef IO_SEQ_MONITOR_STRICT_EN
    chk("t3_fail", fail, 1);
    chk("t3_busy", busy, 0);
`else
    chk("t3_fail", fail, 0);
    chk("t3_busy", busy, 1);
`endif
    chk("t3_step", step_idx, 1);
    chk("t3_last_obs", last_obs, 16'hFFFF);
    pulse_abort(0);
    chk("t3_abort_busy", busy, 0);

    // strict mode: duplicate entry without a new edge
    wr(0, 16'h00AA); wr(1, 16'h00AA); wr(2, 16'h00BB);
    obs_data = 16'h0000;
    arm(3, 0, 1);
    drive(16'h00AA, 2);
    drive(16'h00BB, 1);
    wait_done("t4_done", 20);
    chk("t4_pass", pass, 1);
    chk("t4_step", step_idx, 3);

    // zero-length list passes straight from WAIT_RDY
    arm(0, 0, 0);
    wait_done("t5_done", 5);
    chk("t5_pass", pass, 1);
    chk("t5_step", step_idx, 0);

    // length above DEPTH clamps to 16
    for (int i = 0; i < 16; i++) wr(i, 16'h0007);
    obs_data = 16'h0007;
    arm(31, 0, 0);
    wait_done("t6_done", 40);
    chk("t6_pass", pass, 1);
    chk("t6_step", step_idx, 16);

    // timeout with the bus idle
    wr(0, 16'h5D44);
    obs_data = 16'h0000;
    arm(1, 10, 0);
    wait_done("t7_done", 40);
    chk("t7_timeout", timeout, 1);
    chk("t7_step", step_idx, 0);

    // match in the expiry cycle wins
    arm(1, 10, 0);
    drive(16'h0000, 10);
    drive(16'h5D44, 1);
    wait_done("t8_done", 10);
    chk("t8_pass", pass, 1);
    chk("t8_timeout", timeout, 0);

    // match one cycle too late
    obs_data = 16'h0000;
    arm(1, 10, 0);
    drive(16'h0000, 11);
    drive(16'h5D44, 1);
    wait_done("t9_done", 10);
    chk("t9_timeout", timeout, 1);

    // obs_ready gates entry to RUN; writes while busy are dropped
    obs_ready = 1'b0;
    wr(0, 16'h00C3);
    obs_data = 16'h00C3;
    arm(1, 0, 0);
    repeat (48) @(negedge clock);
    wr(0, 16'h1111);
    chk("t10_busy", busy, 1);
    chk("t10_step", step_idx, 0);
    obs_ready = 1'b1;
    wait_done("t10_done", 10);
    chk("t10_pass", pass, 1);

    // abort together with start mid-run
    wr(0, 16'h0011); wr(1, 16'h0022); wr(2, 16'h0033);
    obs_data = 16'h0000;
    arm(3, 0, 0);
    drive(16'h0011, 2);
    pulse_abort(1);
    chk("t11_busy", busy, 0);
    chk("t11_step", step_idx, 0);
    chk("t11_pass", pass, 0);
    arm(3, 0, 0);
    drive(16'h0011, 1); drive(16'h0022, 1);
    drive(16'h0033, 1);
    wait_done("t11_rerun", 10);
    chk("t11_rerun_pass", pass, 1);
    chk("t11_rerun_step", step_idx, 3);

    // asynchronous reset while in RUN
    obs_data = 16'h0000;
    arm(3, 0, 0);
    drive(16'h0011, 1);
    drive(16'h0022, 1);
    #2 resetb = 1'b0;
    #1;
    chk("t12_busy", busy, 0);
    chk("t12_pass", pass, 0);
    chk("t12_fail", fail, 0);
    chk("t12_timeout", timeout, 0);
    chk("t12_step", step_idx, 0);
    chk("t12_last_obs", last_obs, 0);
    @(negedge clock);
    #2 resetb = 1'b1;
    repeat (3) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
